ram_fifo_slow: RTL and testbench

- Single-clock, RAM-backed FIFO with a registered output stage.
- Used in the router for the output flit buffer (flit_out path) and the output credit buffer (credit plus oport).
- "Slow" means a popped word is refilled from RAM on the following enabled edge, so sustained throughput is one word per two enabled cycles.
- has_data qualifies data_out; full throttles the upstream pipeline; empty feeds the quiescence logic.

---
 rtl/ram_fifo_slow_pkg.sv | 17 +
 rtl/ram_fifo_slow_ram.sv | 50 +++++
 rtl/ram_fifo_slow.sv | 102 ++++++++++
 tb/tb_ram_fifo_slow.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_slow_pkg.sv
// ---------------------------------------------------------------------------
// ram_fifo_slow_pkg
// Constants and helpers shared by the RAM-backed slow FIFO and its RAM.
//   DEFAULT_WIDTH   : default data word width in bits
//   DEFAULT_LOG_DEP : default log2 of the FIFO depth
//   depth_of()      : number of entries for a given log2 depth
// ---------------------------------------------------------------------------
package ram_fifo_slow_pkg;

    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_LOG_DEP = 4;

    function automatic int depth_of(input int log_dep);
        return 1 << log_dep;
    endfunction

endpackage

// File: rtl/ram_fifo_slow_ram.sv
// ---------------------------------------------------------------------------
// simple_dual_port_ram
// One write port and one synchronous read port.
// Ports:
//   clock   : rising-edge clock
//   reset   : asynchronous active-low reset (clears only the read register)
//   wr_en   : write strobe for wr_addr/wr_data
//   wr_addr : write address
//   wr_data : write data
//   rd_en   : read strobe; rd_data captures mem[rd_addr] when high, holds otherwise
//   rd_addr : read address
//   rd_data : registered read data
// ---------------------------------------------------------------------------
module simple_dual_port_ram
    import ram_fifo_slow_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int LOG_DEP = DEFAULT_LOG_DEP
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [LOG_DEP-1:0] wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               rd_en,
    input  logic [LOG_DEP-1:0] rd_addr,
    output logic [WIDTH-1:0]   rd_data
);

    logic [WIDTH-1:0] mem [depth_of(LOG_DEP)];

    // NOTE: the storage array has no reset so it can map onto block or
    // distributed RAM; only the read register below is cleared.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the FIFO output register, so it holds its
    // value whenever no read is requested and clears to zero on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ram_fifo_slow.sv
// ---------------------------------------------------------------------------
// ram_fifo_slow
// Single-clock RAM-backed FIFO with a registered output word. A popped word
// is refilled from RAM on the following enabled edge, so sustained throughput
// is one word every two enabled cycles.
// Ports:
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset; discards all entries
//   enable   : global advance; when low, all state holds
//   data_in  : write data
//   write    : push request (dropped while full)
//   read     : pop request (acts only while has_data is high)
//   data_out : registered oldest word, valid while has_data is high
//   full     : count == DEPTH
//   empty    : count == 0
//   has_data : data_out holds the oldest unpopped word
// ---------------------------------------------------------------------------
module ram_fifo_slow
    import ram_fifo_slow_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int LOG_DEP = DEFAULT_LOG_DEP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    input  logic             write,
    input  logic             read,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             has_data
);

    localparam int               DEPTH      = depth_of(LOG_DEP);
    localparam logic [LOG_DEP:0] FULL_COUNT = (LOG_DEP + 1)'(DEPTH);

    logic [LOG_DEP-1:0] wr_ptr;
    logic [LOG_DEP-1:0] rd_ptr;
    logic [LOG_DEP:0]   count;

    logic push;
    logic pop;
    logic load;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // All three events use pre-edge state: a push while full is dropped even
    // if a pop frees a slot on the same edge, and a word written this edge is
    // not yet counted, so it cannot be loaded until the next one.
    assign push = enable && write && !full;
    assign pop  = enable && read && has_data;
    // A load needs has_data low, which already excludes a pop on this edge.
    assign load = enable && !has_data && !empty;

    simple_dual_port_ram #(
        .WIDTH   (WIDTH),
        .LOG_DEP (LOG_DEP)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (load),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            has_data <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            // rd_ptr only advances on pop: a loaded word keeps its RAM slot
            // until it leaves the FIFO, so count covers it.
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                has_data <= 1'b0;
            end else if (load) begin
                has_data <= 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_fifo_slow.sv
// ---------------------------------------------------------------------------
// tb_ram_fifo_slow
// Self-checking bench for ram_fifo_slow. A queue-based reference model tracks
// FIFO contents and whether the head word is presented; a scoreboard of
// accepted writes is checked by an independent monitor on every pop.
// ---------------------------------------------------------------------------
module tb_ram_fifo_slow;

    localparam int WIDTH   = 16;
    localparam int LOG_DEP = 4;
    localparam int DEPTH   = 16;

    logic             clock   = 1'b0;
    logic             reset   = 1'b0;
    logic             enable  = 1'b0;
    logic             write   = 1'b0;
    logic             read    = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             has_data;

    ram_fifo_slow #(
        .WIDTH   (WIDTH),
        .LOG_DEP (LOG_DEP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .data_in  (data_in),
        .write    (write),
        .read     (read),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
        .has_data (has_data)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: accepted words in write order, consumed by the monitor.
    logic [WIDTH-1:0] sb [$];

    // Reference model: FIFO contents, head-presented flag, last output word.
    logic [WIDTH-1:0] mq [$];
    bit               m_pres = 1'b0;
    logic [WIDTH-1:0] m_out  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: inputs are stable at the falling edge, so a pop about to be
    // accepted is visible here; the presented word must match the scoreboard.
    always @(negedge clock) begin
        if (reset && enable && read && has_data) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%0h expected no pop at %0t", data_out, $time);
            end else begin
                check("pop_word", data_out, sb.pop_front());
            end
        end
    end

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_pres = 1'b0;
        m_out  = '0;
    endtask

    task automatic model_edge(input bit en, input bit w, input bit r, input logic [WIDTH-1:0] d);
        int pre;
        if (!en) return;
        pre = mq.size();
        if (r && m_pres) begin
            void'(mq.pop_front());
            m_pres = 1'b0;
        end else if (!m_pres && pre > 0) begin
            m_pres = 1'b1;
            m_out  = mq[0];
        end
        if (w && pre < DEPTH) begin
            mq.push_back(d);
            sb.push_back(d);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_has_data"}, 32'(has_data), 32'(m_pres));
        check({tag, "_empty"},    32'(empty),    32'(mq.size() == 0));
        check({tag, "_full"},     32'(full),     32'(mq.size() == DEPTH));
        check({tag, "_data_out"}, 32'(data_out), 32'(m_out));
    endtask

    // Called just after a rising edge; applies inputs for the next edge.
    task automatic step(input bit en, input bit w, input bit r, input logic [WIDTH-1:0] d,
                        input string tag);
        enable  = en;
        write   = w;
        read    = r;
        data_in = d;
        @(posedge clock);
        #1;
        model_edge(en, w, r, d);
        check_outputs(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4 * DEPTH + 8 && mq.size() > 0; i++) begin
            step(1'b1, 1'b0, 1'b1, '0, tag);
        end
        if (mq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: %0d words left, required 0", tag, mq.size());
        end
    endtask

    initial begin
        // Reset asserted from time zero and released between edges.
        #23 reset = 1'b1;
        @(posedge clock);
        #1;
        check_outputs("reset");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0, "idle");

        // Single word.
        step(1'b1, 1'b1, 1'b0, 16'h00A5, "single_w");
        step(1'b1, 1'b0, 1'b0, '0, "single_load");
        check("single_value", 32'(data_out), 32'h00A5);
        check("single_valid", 32'(has_data), 32'd1);
        step(1'b1, 1'b0, 1'b1, '0, "single_pop");
        check("single_empty", 32'(empty), 32'd1);

        // Ordering and throughput with read held high.
        step(1'b1, 1'b1, 1'b1, 16'h0001, "ord");
        step(1'b1, 1'b1, 1'b1, 16'h0002, "ord");
        check("ord_first", 32'(data_out), 32'h0001);
        step(1'b1, 1'b1, 1'b1, 16'h0003, "ord");
        check("ord_gap", 32'(has_data), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, '0, "ord_tail");
        check("ord_last", 32'(data_out), 32'h0003);

        // Fill, overflow, drain and refill across the pointer wrap.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, 16'(i), "fill");
        check("fill_full", 32'(full), 32'd1);
        step(1'b1, 1'b1, 1'b0, 16'h00FF, "overflow");
        drain("fill_drain");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 16'(16'h20 + i), "refill");
        drain("refill_drain");

        // Enable gating.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'(16'h40 + i), "gate_pre");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 16'($urandom), "gate_off");
        drain("gate_drain");

        // Simultaneous push and pop at count 4.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 16'(16'h50 + i), "sim_pre");
        step(1'b1, 1'b1, 1'b1, 16'h0077, "sim_pp");
        check("sim_not_full", 32'(full), 32'd0);
        drain("sim_drain");

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(9, 0) != 0), 1'($urandom), 1'($urandom), 16'($urandom), "rand");
        end
        drain("rand_drain");

        // Asynchronous reset mid-operation, between clock edges.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'(16'h60 + i), "pre_rst");
        enable = 1'b0;
        write  = 1'b0;
        read   = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock);
        #1;
        check_outputs("post_rst");
        step(1'b1, 1'b1, 1'b0, 16'h0099, "post_rst_w");
        drain("post_rst_drain");

        check("sb_leftover", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
